// File: rtl/icu_sequencer.sv
// Program sequencer for a 1-bit industrial control unit (ICU).
// Fetches {opcode, operand} words from program memory, issues the opcode to
// the ICU one cycle later, and handles JMP/RTN through a small return stack
// and SKZ through squashing of the following fetched word.
module icu_sequencer #(
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    output logic [7:0]  rom_addr,
    input  logic [11:0] rom_data,
    input  logic        rr_in,
    output logic [3:0]  icu_instr,
    output logic [7:0]  io_addr,
    output logic        busy,
    output logic        halted,
    output logic [1:0]  err
);

    localparam int unsigned PtrW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned SpW  = PtrW + 1;

    localparam logic [3:0] OpNopo = 4'h0;
    localparam logic [3:0] OpJmp  = 4'hC;
    localparam logic [3:0] OpRtn  = 4'hD;
    localparam logic [3:0] OpSkz  = 4'hE;

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e         state_q, state_d;
    logic [7:0]     pc_q, pc_d;
    logic [3:0]     ir_q, ir_d;
    logic [7:0]     io_q, io_d;
    logic [SpW-1:0] sp_q, sp_d;
    logic [1:0]     err_q, err_d;
    logic           busy_q, halted_q;
    logic [7:0]     stack_q [STACK_DEPTH];

    logic [3:0]     fetch_op;
    logic [7:0]     fetch_arg;
    logic [7:0]     pc_inc;
    logic [SpW-1:0] sp_dec;
    logic           skip;
    logic           push;

    assign fetch_op  = rom_data[11:8];
    assign fetch_arg = rom_data[7:0];
    assign pc_inc    = pc_q + 8'd1;
    assign sp_dec    = sp_q - SpW'(1);
    // The pending-skip flag is the issued SKZ itself: IR is forced to NOPO on
    // stop, reset and error, which discards any pending skip.
    assign skip      = (ir_q == OpSkz) && !rr_in;

    // Next-state decode for the sequencer FSM, PC, IR and return stack.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        io_d    = io_q;
        sp_d    = sp_q;
        err_d   = err_q;
        push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                ir_d = OpNopo;
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (stop) begin
                    // Fetched word is not consumed; PC stays on it.
                    state_d = StIdle;
                    ir_d    = OpNopo;
                    io_d    = 8'h00;
                end else if (skip) begin
                    ir_d = OpNopo;
                    io_d = 8'h00;
                    pc_d = pc_inc;
                end else if (fetch_op == OpJmp) begin
                    if (sp_q == SpW'(STACK_DEPTH)) begin
                        state_d = StHalt;
                        ir_d    = OpNopo;
                        io_d    = 8'h00;
                        err_d   = 2'd1;
                    end else begin
                        push = 1'b1;
                        sp_d = sp_q + SpW'(1);
                        pc_d = fetch_arg;
                        ir_d = fetch_op;
                        io_d = fetch_arg;
                    end
                end else if (fetch_op == OpRtn) begin
                    if (sp_q == '0) begin
                        state_d = StHalt;
                        ir_d    = OpNopo;
                        io_d    = 8'h00;
                        err_d   = 2'd2;
                    end else begin
                        sp_d = sp_dec;
                        pc_d = stack_q[sp_dec[PtrW-1:0]];
                        ir_d = fetch_op;
                        io_d = fetch_arg;
                    end
                end else begin
                    pc_d = pc_inc;
                    ir_d = fetch_op;
                    io_d = fetch_arg;
                end
            end
            StHalt: begin
                ir_d = OpNopo;
                io_d = 8'h00;
            end
            default: begin
                state_d = StIdle;
                ir_d    = OpNopo;
            end
        endcase
    end

    // State registers with registered busy/halted decodes of the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            pc_q     <= 8'h00;
            ir_q     <= OpNopo;
            io_q     <= 8'h00;
            sp_q     <= '0;
            err_q    <= 2'd0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            io_q     <= io_d;
            sp_q     <= sp_d;
            err_q    <= err_d;
            busy_q   <= (state_d == StRun);
            halted_q <= (state_d == StHalt);
        end
    end

    // Return-stack storage; validity is tracked solely by sp_q.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[sp_q[PtrW-1:0]] <= pc_inc;
        end
    end

    assign rom_addr  = pc_q;
    assign icu_instr = (state_q == StRun) ? ir_q : OpNopo;
    assign io_addr   = io_q;
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign err       = err_q;

endmodule

// File: tb/tb_icu_sequencer.sv
// Directed testbench for icu_sequencer: a per-cycle vector table for the
// straight-line/skip/call program plus hand-written corner-case sequences.
module tb_icu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [7:0]  rom_addr;
    logic [11:0] rom_data;
    logic        rr_in;
    logic [3:0]  icu_instr;
    logic [7:0]  io_addr;
    logic        busy;
    logic        halted;
    logic [1:0]  err;

    logic [11:0] rom [256];
    int          n_tests = 0;
    int          n_fail  = 0;

    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    icu_sequencer #(.STACK_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rr_in     (rr_in),
        .icu_instr (icu_instr),
        .io_addr   (io_addr),
        .busy      (busy),
        .halted    (halted),
        .err       (err)
    );

    typedef struct {
        logic       start;
        logic       stop;
        logic       rr;
        logic [3:0] instr;
        logic [7:0] io;
        logic [7:0] addr;
        logic       busy;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) rom[i] = 12'hF00;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        rr_in = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // {start, stop, rr, icu_instr, io_addr, rom_addr, busy} after each edge
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'h1, 8'h03, 8'h01, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'h5, 8'h05, 8'h02, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'h8, 8'h07, 8'h03, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'hF, 8'h00, 8'h04, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'hF, 8'h00, 8'h05, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'hE, 8'h00, 8'h06, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h07, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'hC, 8'h05, 8'h05, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'hE, 8'h00, 8'h06, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 4'hC, 8'h20, 8'h20, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4'hD, 8'h00, 8'h07, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 4'hC, 8'h05, 8'h05, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 8'h05, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h05, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 8'h05, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 4'hE, 8'h00, 8'h06, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h07, 1'b1};

        // Straight-line, skip and call/return program
        rom_clear();
        rom[8'h00] = 12'h103;
        rom[8'h01] = 12'h505;
        rom[8'h02] = 12'h807;
        rom[8'h05] = 12'hE00;
        rom[8'h06] = 12'hC20;
        rom[8'h07] = 12'hC05;
        rom[8'h20] = 12'hD00;

        do_reset();
        check("reset_addr", rom_addr, 8'h00);
        check("reset_instr", icu_instr, 4'h0);
        check("reset_io", io_addr, 8'h00);
        check("reset_busy", busy, 1'b0);
        check("reset_halted", halted, 1'b0);
        check("reset_err", err, 2'd0);
        tick();
        check("hold_after_reset_busy", busy, 1'b0);
        check("hold_after_reset_addr", rom_addr, 8'h00);

        for (int i = 0; i < 18; i++) begin
            start = vecs[i].start;
            stop  = vecs[i].stop;
            rr_in = vecs[i].rr;
            tick();
            check($sformatf("vec%0d_instr", i), icu_instr, vecs[i].instr);
            check($sformatf("vec%0d_io", i), io_addr, vecs[i].io);
            check($sformatf("vec%0d_addr", i), rom_addr, vecs[i].addr);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("vec%0d_halted", i), halted, 1'b0);
            check($sformatf("vec%0d_err", i), err, 2'd0);
        end
        start = 1'b0;
        stop  = 1'b0;
        rr_in = 1'b0;

        // Call and return, then RTN at address 2 proves the stack is empty
        rom_clear();
        rom[8'h00] = 12'hC40;
        rom[8'h40] = 12'hD00;
        rom[8'h02] = 12'hD00;
        do_reset();
        do_start();
        check("call_pc0", rom_addr, 8'h00);
        tick();
        check("call_instr", icu_instr, 4'hC);
        check("call_pc40", rom_addr, 8'h40);
        tick();
        check("ret_instr", icu_instr, 4'hD);
        check("ret_pc1", rom_addr, 8'h01);
        tick();
        check("after_ret_instr", icu_instr, 4'hF);
        check("after_ret_pc", rom_addr, 8'h02);
        tick();
        check("empty_err", err, 2'd2);
        check("empty_halted", halted, 1'b1);
        check("empty_pc_held", rom_addr, 8'h02);

        // Overflow: five nested JMPs with a four-entry stack
        rom_clear();
        for (int i = 0; i < 5; i++) rom[i] = 12'hC00 | 12'(i + 1);
        do_reset();
        do_start();
        for (int i = 0; i < 4; i++) tick();
        check("ovf_4th_ok_err", err, 2'd0);
        check("ovf_4th_ok_pc", rom_addr, 8'h04);
        tick();
        check("ovf_err", err, 2'd1);
        check("ovf_halted", halted, 1'b1);
        check("ovf_busy", busy, 1'b0);
        check("ovf_instr", icu_instr, 4'h0);
        check("ovf_pc_held", rom_addr, 8'h04);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        check("halt_sticky", halted, 1'b1);
        check("halt_err_sticky", err, 2'd1);

        // Underflow: RTN as the first instruction
        rom_clear();
        rom[8'h00] = 12'hD00;
        do_reset();
        check("rst_clears_err", err, 2'd0);
        check("rst_clears_halted", halted, 1'b0);
        do_start();
        tick();
        check("unf_err", err, 2'd2);
        check("unf_halted", halted, 1'b1);
        check("unf_instr", icu_instr, 4'h0);

        // Stop while JMP is being fetched; RTN at 1 proves exactly one push
        rom_clear();
        rom[8'h00] = 12'hC10;
        rom[8'h11] = 12'hD00;
        rom[8'h01] = 12'hD00;
        do_reset();
        do_start();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_pc_held", rom_addr, 8'h00);
        check("stop_instr", icu_instr, 4'h0);
        check("stop_busy", busy, 1'b0);
        do_start();
        tick();
        check("resume_jmp_instr", icu_instr, 4'hC);
        check("resume_jmp_pc", rom_addr, 8'h10);
        tick();
        tick();
        check("resume_ret_pc", rom_addr, 8'h01);
        tick();
        check("resume_one_push", err, 2'd2);

        // PC wrap and asynchronous reset between edges
        rom_clear();
        rom[8'h00] = 12'hCFE;
        do_reset();
        do_start();
        tick();
        check("wrap_pc_fe", rom_addr, 8'hFE);
        tick();
        check("wrap_pc_ff", rom_addr, 8'hFF);
        tick();
        check("wrap_pc_00", rom_addr, 8'h00);
        tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_addr", rom_addr, 8'h00);
        check("async_rst_instr", icu_instr, 4'h0);
        check("async_rst_io", io_addr, 8'h00);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_halted", halted, 1'b0);
        check("async_rst_err", err, 2'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_idle", busy, 1'b0);
        check("post_rst_pc", rom_addr, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
